alu_issue: RTL

Instruction issue and writeback front-end for the 16-bit `alu`. It accepts 16-bit instruction words over a valid/ready handshake, decodes them and reads operands from an internal 8×16 register file. It then drives the `alu` `op`/`a`/`b` inputs from registers and captures `result` into the register file and a registered output port. It sits between the instruction source and the combinational `alu`, which is instantiated alongside it and not inside it.

---
 rtl/alu_issue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: instruction issue and writeback front-end for the 16-bit alu.
// Decodes R-type / LI instruction words, reads operands from an 8x16
// register file (R0 hard-wired to zero), drives the external combinational
// alu from registers (EX stage) and captures its result into the register
// file and a registered output port (OUT stage).
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic [15:0] out_data,
  output logic [2:0]  out_rd,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [2:0] OP_ADD = 3'd0;

  // Register file; entry 0 is never written and R0 reads are forced to zero.
  logic [15:0] regs [8];

  // EX stage bookkeeping (alu_op/alu_a/alu_b are the EX operand registers).
  logic        ex_valid;
  logic [2:0]  ex_rd;

  // Handshake / pipeline control.
  logic        ex_adv;
  logic        accept;

  // Instruction fields.
  logic        is_li;
  logic [2:0]  dec_op;
  logic [2:0]  dec_rd;
  logic [2:0]  dec_rs;
  logic [2:0]  dec_rt;
  logic [7:0]  dec_imm;
  logic        unused_bits;

  // Operand values after register read and bypass.
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic [2:0]  nxt_op;
  logic [15:0] nxt_a;
  logic [15:0] nxt_b;

  assign is_li       = in_instr[15];
  assign dec_op      = in_instr[14:12];
  assign dec_rd      = in_instr[11:9];
  assign dec_rs      = in_instr[8:6];
  assign dec_rt      = in_instr[5:3];
  assign dec_imm     = in_instr[7:0];
  assign unused_bits = ^in_instr[2:0];

  // EX retires whenever OUT is empty or being drained this cycle.
  assign ex_adv   = ex_valid & (~out_valid | out_ready);
  assign in_ready = rst_n & (~ex_valid | ex_adv);
  assign accept   = in_valid & in_ready;

  // Operand read: R0 is zero, otherwise forward the retiring EX result when
  // it targets the same register, since the register file write lands on
  // the same edge as this read is captured.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rs_val = regs[dec_rs];
    rt_val = regs[dec_rt];
    if (dec_rs == 3'd0) begin
      rs_val = 16'h0000;
    end else if (ex_adv && (dec_rs == ex_rd)) begin
      rs_val = alu_result;
    end
    if (dec_rt == 3'd0) begin
      rt_val = 16'h0000;
    end else if (ex_adv && (dec_rt == ex_rd)) begin
      rt_val = alu_result;
    end
  end

  // Decode into the values the alu operand registers take on accept.
  always_comb begin
    nxt_op = dec_op;
    nxt_a  = rs_val;
    nxt_b  = rt_val;
    if (is_li) begin
      nxt_op = OP_ADD;
      nxt_a  = 16'h0000;
      nxt_b  = {8'h00, dec_imm};
    end
  end

  // Pipeline state, output port and register file writeback.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_rd     <= 3'd0;
      alu_op    <= 3'd0;
      alu_a     <= 16'h0000;
      alu_b     <= 16'h0000;
      out_valid <= 1'b0;
      out_rd    <= 3'd0;
      out_data  <= 16'h0000;
      // NOTE: the register file is a flop array with architecturally defined reset
      // contents, so it is cleared here; a RAM-backed file could not be.
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      if (accept) begin
        ex_valid <= 1'b1;
        ex_rd    <= dec_rd;
        alu_op   <= nxt_op;
        alu_a    <= nxt_a;
        alu_b    <= nxt_b;
      end else if (ex_adv) begin
        ex_valid <= 1'b0;
      end

      if (ex_adv) begin
        out_valid <= 1'b1;
        out_rd    <= ex_rd;
        out_data  <= alu_result;
        if (ex_rd != 3'd0) begin
          regs[ex_rd] <= alu_result;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
